serial_frame_tx: RTL and testbench

Parallel-to-serial frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on one line as a UART-style frame. A frame is a start bit, the data bits LSB first, an optional even-parity bit and a stop bit. The block is the transmit end of the single-wire serial link used by the team's example designs. It drives the line that the serial receiver samples, and it is exercised through the same interface/test/dut bench structure as the other blocks.

---
 rtl/serial_frame_tx.sv | 141 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial UART-style frame transmitter. A WIDTH-bit word is
//   accepted over a valid/ready handshake. It is then sent on one line as:
//   start bit (0), data LSB first, optional even-parity bit, stop bit (1).
//   Every line bit is held for CLKS_PER_BIT clocks.
//
// Ports
//   clk       clock, all logic on posedge
//   rst       synchronous active-low reset
//   tx_data   word to send, sampled only at acceptance
//   tx_valid  word available
//   tx_ready  block can accept a word (registered, high only in IDLE)
//   tx_out    serial line, idle high (registered)
//   busy      frame in progress (registered)
//   done      one-cycle pulse in the first IDLE cycle after the stop bit
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [BW-1:0]    baud, baud_n;
    logic [NW-1:0]    bit_cnt, bit_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic             par, par_n;
    logic             baud_end;
    logic             line_n, done_n;

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_cnt;
        shift_n  = shift;
        par_n    = par;
        done_n   = 1'b0;
        line_n   = 1'b1;
        baud_end = (baud == BAUD_LAST);

        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    shift_n = tx_data;
                    par_n   = ^tx_data;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + NW'(1);
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n  = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line is registered, so it is derived from the state being entered.
        // In DATA the shifted value already presents the next bit in bit 0.
        unique case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift_n[0];
            PARITY:  line_n = par_n;
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par      <= par_n;
            tx_out   <= line_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            tx_ready <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Self-checking bench for serial_frame_tx. Two instances are used:
//   8 bits / 4 clocks per bit / parity, and 8 bits / 1 clock per bit / no parity.
//   The expected line is computed per cycle from the frame definition.
module tb_serial_frame_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int P   = 1;
    localparam int F   = (2 + W + P) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready, tx_out, busy, done;
    logic       tx_ready1, tx_out1, busy1, done1;

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(P)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: line value k cycles after the acceptance edge.
    function automatic logic exp_line(input logic [7:0] d, input int k,
                                      input int w, input int cpb, input int p);
        int idx;
        idx = k / cpb;
        if (idx == 0) return 1'b0;
        if (idx <= w) return d[idx-1];
        if (p != 0 && idx == w + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_tx_out", tx_out, 1);
            check("idle_busy", busy, 0);
            check("idle_ready", tx_ready, 1);
            check("idle_done", done, 0);
        end
    endtask

    // Called just after an edge with the DUT idle. Returns after edge E0+F
    // (done cycle) with the line sampled mid-bit into got/got_par.
    task automatic send(input logic [7:0] d, input logic keep, input logic [7:0] nd,
                        input int abort_k, output logic [7:0] got, output logic got_par);
        int idx;
        got     = '0;
        got_par = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = keep;
        tx_data  = nd;
        for (int k = 0; k < F; k++) begin
            if (k == abort_k) begin
                tx_valid = 1'b0;
                rst = 1'b0;
                tick();
                rst = 1'b1;
                check("abort_tx_out", tx_out, 1);
                check("abort_busy", busy, 0);
                check("abort_ready", tx_ready, 1);
                check("abort_done", done, 0);
                for (int j = 0; j < F; j++) begin
                    tick();
                    check("abort_no_done", done, 0);
                    check("abort_line_idle", tx_out, 1);
                end
                return;
            end
            check("line", tx_out, exp_line(d, k, W, CPB, P));
            check("busy", busy, 1);
            check("ready_low", tx_ready, 0);
            check("done_low", done, 0);
            if (k % CPB == CPB / 2) begin
                idx = k / CPB;
                if (idx >= 1 && idx <= W) got[idx-1] = tx_out;
                if (idx == W + 1) got_par = tx_out;
            end
            tick();
        end
        check("end_done", done, 1);
        check("end_ready", tx_ready, 1);
        check("end_busy", busy, 0);
        check("end_tx_out", tx_out, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic [7:0] next;
        logic       exp_par;
        int         gap;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] got, cur, nd;
        logic       gp, keep;

        tbl[0] = '{8'hA5, 1'b0, 8'h00, 1'b0, 2};
        tbl[1] = '{8'h01, 1'b1, 8'hFF, 1'b1, 0};
        tbl[2] = '{8'hFF, 1'b0, 8'h00, 1'b0, 1};
        tbl[3] = '{8'h3C, 1'b1, 8'hFF, 1'b0, 0};
        tbl[4] = '{8'hFF, 1'b0, 8'h00, 1'b0, 3};
        tbl[5] = '{8'h80, 1'b0, 8'h00, 1'b1, 1};

        rst = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        tx_valid1 = 1'b0;
        tx_data1 = 8'h00;

        // Reset held with a word offered: nothing is accepted.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_tx_out", tx_out, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ready", tx_ready, 1);
            check("rst_tx_out1", tx_out1, 1);
            check("rst_ready1", tx_ready1, 1);
        end
        rst = 1'b1;
        send(8'h5A, 1'b0, 8'h00, -1, got, gp);
        check("rst_release_data", got, 8'h5A);
        idle(2);

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].keep, tbl[i].next, -1, got, gp);
            check("tbl_data", got, tbl[i].data);
            check("tbl_par", gp, tbl[i].exp_par);
            if (tbl[i].gap > 0) idle(tbl[i].gap);
        end

        // Reset during data bit 3 of 0x55, then a clean 0x0F frame.
        send(8'h55, 1'b0, 8'h00, 4 * CPB + 1, got, gp);
        send(8'h0F, 1'b0, 8'h00, -1, got, gp);
        check("post_abort_data", got, 8'h0F);
        check("post_abort_par", gp, 1'b0);
        idle(1);

        // One clock per bit, no parity: 0x00 gives a 10-cycle frame.
        tx_valid1 = 1'b1;
        tx_data1  = 8'h00;
        tick();
        tx_valid1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("np_line", tx_out1, exp_line(8'h00, k, 8, 1, 0));
            check("np_busy", busy1, 1);
            check("np_done_low", done1, 0);
            tick();
        end
        check("np_done", done1, 1);
        check("np_ready", tx_ready1, 1);
        check("np_tx_out", tx_out1, 1);
        tick();
        check("np_done_once", done1, 0);

        // Random words, random back-to-back / gaps.
        cur = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            keep = 1'($urandom_range(0, 1));
            nd   = 8'($urandom);
            send(cur, keep, nd, -1, got, gp);
            check("rnd_data", got, cur);
            check("rnd_par", gp, ^cur);
            if (keep) begin
                cur = nd;
            end else begin
                cur = 8'($urandom);
                idle($urandom_range(0, 3));
            end
        end
        tx_valid = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
